// File: rtl/sdm_adc_frame_receiver_if.sv
// ============================================================================
// Module      : sdm_adc_frame_receiver_if
// Description : 64-bit AXI-stream link word channel into the frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdm_adc_frame_receiver_if;
  logic [63:0] S_AXI_RX_TDATA;
  logic        S_AXI_RX_TVALID;
  logic        S_AXI_RX_TLAST;
  logic        S_AXI_RX_TREADY;

  modport master (
    output S_AXI_RX_TDATA,
    output S_AXI_RX_TVALID,
    output S_AXI_RX_TLAST,
    input  S_AXI_RX_TREADY
  );

  modport slave (
    input  S_AXI_RX_TDATA,
    input  S_AXI_RX_TVALID,
    input  S_AXI_RX_TLAST,
    output S_AXI_RX_TREADY
  );
endinterface

`default_nettype wire

// File: rtl/sdm_adc_frame_receiver.sv
// ============================================================================
// Module      : sdm_adc_frame_receiver
// Description : Reassembles 512-bit frames from 8 link words, checks framing
//               and the 2-bit sequence tag, unpacks ADC and SDM samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdm_adc_frame_receiver #(
  parameter int NCH_ADC       = 20,
  parameter int NCH_SDM       = 19,
  parameter int SDM_PER_FRAME = 5
) (
  input  wire logic                   CLK,
  input  wire logic                   RESET,
  sdm_adc_frame_receiver_if.slave     s_axi_rx,
  output logic [511:0]                DOUT,
  output logic                        DOUT_VALID,
  output logic [NCH_ADC*16-1:0]       ADC_Q,
  output logic                        ADC_Q_VALID,
  output logic [NCH_SDM*2-1:0]        SDM_Q,
  output logic                        SDM_Q_VALID,
  output logic [15:0]                 FRAME_ERR_CNT,
  output logic [15:0]                 SEQ_ERR_CNT
);

  localparam int A_W   = NCH_ADC * 16;
  localparam int S_W   = NCH_SDM * 2;
  localparam int SH_W  = SDM_PER_FRAME * S_W;
  localparam int CNT_W = $clog2(SDM_PER_FRAME + 1);

  if (A_W + SH_W > 510) begin : g_param_check
    $error("sdm_adc_frame_receiver: ADC + SDM fields overlap the sequence tag");
  end

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_RESYNC  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [447:0]       buf_q, buf_d;
  logic               tready_q, tready_d;
  logic [511:0]       dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic [A_W-1:0]     adc_q, adc_d;
  logic               adc_valid_q, adc_valid_d;
  logic [S_W-1:0]     sdm_q, sdm_d;
  logic               sdm_valid_q, sdm_valid_d;
  logic [SH_W-1:0]    shadow_q, shadow_d;
  logic [CNT_W-1:0]   left_q, left_d;
  logic [15:0]        ferr_q, ferr_d;
  logic [15:0]        serr_q, serr_d;
  logic               armed_q, armed_d;
  logic [1:0]         exp_q, exp_d;

  logic               accept;
  logic [511:0]       frame;
  logic [1:0]         tag;
  logic               frame_done;
  logic               frame_bad;

  assign accept = s_axi_rx.S_AXI_RX_TVALID & tready_q;
  assign frame  = {s_axi_rx.S_AXI_RX_TDATA, buf_q};
  assign tag    = s_axi_rx.S_AXI_RX_TDATA[63:62];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    tready_d     = 1'b1;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    adc_d        = adc_q;
    adc_valid_d  = 1'b0;
    sdm_d        = sdm_q;
    sdm_valid_d  = 1'b0;
    shadow_d     = shadow_q;
    left_d       = left_q;
    ferr_d       = ferr_q;
    serr_d       = serr_q;
    armed_d      = armed_q;
    exp_d        = exp_q;
    frame_done   = 1'b0;
    frame_bad    = 1'b0;

    if (accept) begin
      case (state_q)
        ST_COLLECT: begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (s_axi_rx.S_AXI_RX_TLAST) begin
              frame_done = 1'b1;
            end else begin
              frame_bad = 1'b1;
              state_d   = ST_RESYNC;
            end
          end else if (s_axi_rx.S_AXI_RX_TLAST) begin
            idx_d     = 3'd0;
            frame_bad = 1'b1;
          end else begin
            buf_d[64*idx_q +: 64] = s_axi_rx.S_AXI_RX_TDATA;
            idx_d                 = idx_q + 3'd1;
          end
        end
        ST_RESYNC: begin
          // Discard everything up to and including the next TLAST word.
          if (s_axi_rx.S_AXI_RX_TLAST) begin
            state_d = ST_COLLECT;
            idx_d   = 3'd0;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end

    if (frame_done) begin
      dout_d       = frame;
      dout_valid_d = 1'b1;
      adc_d        = frame[A_W-1:0];
      adc_valid_d  = 1'b1;
      sdm_d        = frame[A_W +: S_W];
      sdm_valid_d  = 1'b1;
      shadow_d     = frame[A_W +: SH_W] >> S_W;
      left_d       = CNT_W'(SDM_PER_FRAME - 1);
      armed_d      = 1'b1;
      exp_d        = tag + 2'd1;
      if (armed_q && (tag != exp_q) && (serr_q != 16'hFFFF)) begin
        serr_d = serr_q + 16'd1;
      end
    end else if (left_q != '0) begin
      sdm_d       = shadow_q[S_W-1:0];
      sdm_valid_d = 1'b1;
      shadow_d    = shadow_q >> S_W;
      left_d      = left_q - CNT_W'(1);
    end

    if (frame_bad) begin
      armed_d = 1'b0;
      if (ferr_q != 16'hFFFF) begin
        ferr_d = ferr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_COLLECT;
      idx_q        <= 3'd0;
      buf_q        <= '0;
      tready_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      adc_q        <= '0;
      adc_valid_q  <= 1'b0;
      sdm_q        <= '0;
      sdm_valid_q  <= 1'b0;
      shadow_q     <= '0;
      left_q       <= '0;
      ferr_q       <= 16'd0;
      serr_q       <= 16'd0;
      armed_q      <= 1'b0;
      exp_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      tready_q     <= tready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      adc_q        <= adc_d;
      adc_valid_q  <= adc_valid_d;
      sdm_q        <= sdm_d;
      sdm_valid_q  <= sdm_valid_d;
      shadow_q     <= shadow_d;
      left_q       <= left_d;
      ferr_q       <= ferr_d;
      serr_q       <= serr_d;
      armed_q      <= armed_d;
      exp_q        <= exp_d;
    end
  end

  assign s_axi_rx.S_AXI_RX_TREADY = tready_q;
  assign DOUT          = dout_q;
  assign DOUT_VALID    = dout_valid_q;
  assign ADC_Q         = adc_q;
  assign ADC_Q_VALID   = adc_valid_q;
  assign SDM_Q         = sdm_q;
  assign SDM_Q_VALID   = sdm_valid_q;
  assign FRAME_ERR_CNT = ferr_q;
  assign SEQ_ERR_CNT   = serr_q;

endmodule

`default_nettype wire
